// File: rtl/recompute_pkg.sv
// -----------------------------------------------------------------------------
// recompute_pkg
//   Shared constants for the BISR recompute-unit controller.
//   - DEFAULT_ROWS / DEFAULT_COLS : systolic array geometry.
//   - DEFAULT_NUM_RU              : number of spare recompute units.
//   - PE_PASS / PE_FAIL           : encoding of one entry of the STW result
//                                   matrix (1 = PE passed, 0 = PE faulty).
// -----------------------------------------------------------------------------
package recompute_pkg;

    localparam int DEFAULT_ROWS   = 3;
    localparam int DEFAULT_COLS   = 3;
    localparam int DEFAULT_NUM_RU = 3;

    localparam logic PE_PASS = 1'b1;
    localparam logic PE_FAIL = 1'b0;

    // One-hot of a row or column index, returned at full integer width and
    // truncated by the caller to the vector it is filling.
    function automatic logic [31:0] index_onehot(input int idx);
        index_onehot = 32'd1 << idx;
    endfunction

endpackage : recompute_pkg

// File: rtl/ru_fault_allocator.sv
// -----------------------------------------------------------------------------
// ru_fault_allocator
//   Purely combinational row-major priority scan of the STW pass/fail matrix.
//   The n-th faulty PE found (n < NUM_RU) is assigned to recompute unit n;
//   any faults beyond NUM_RU raise fault_overflow and are otherwise ignored.
//
// Ports
//   stw_result_mat  in   [0:ROWS-1][0:COLS-1]  1 = pass, 0 = faulty
//   ru_row          out  [ROWS-1:0] x NUM_RU   one-hot row of assigned PE
//   ru_col          out  [COLS-1:0] x NUM_RU   one-hot column of assigned PE
//   ru_active       out  NUM_RU                RU k holds an assignment
//   fault_overflow  out  1                     more faults than RUs
// -----------------------------------------------------------------------------
module ru_fault_allocator
    import recompute_pkg::*;
#(
    parameter int ROWS   = DEFAULT_ROWS,
    parameter int COLS   = DEFAULT_COLS,
    parameter int NUM_RU = DEFAULT_NUM_RU
) (
    input  logic            stw_result_mat [0:ROWS-1][0:COLS-1],
    output logic [ROWS-1:0] ru_row         [NUM_RU-1:0],
    output logic [COLS-1:0] ru_col         [NUM_RU-1:0],
    output logic [NUM_RU-1:0] ru_active,
    output logic            fault_overflow
);

    // Number of faults already assigned during the current scan.
    int found;

    always_comb begin
        // NOTE: every output gets a default before the scan so that paths
        // which never hit a fault cannot infer a latch.
        for (int k = 0; k < NUM_RU; k++) begin
            ru_row[k] = '0;
            ru_col[k] = '0;
        end
        ru_active      = '0;
        fault_overflow = 1'b0;
        found          = 0;

        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (stw_result_mat[r][c] == PE_FAIL) begin
                    if (found < NUM_RU) begin
                        // Constant-index fan-out keeps the RU select a
                        // simple comparator instead of a variable index.
                        for (int k = 0; k < NUM_RU; k++) begin
                            if (k == found) begin
                                ru_row[k]    = ROWS'(index_onehot(r));
                                ru_col[k]    = COLS'(index_onehot(c));
                                ru_active[k] = 1'b1;
                            end
                        end
                        found = found + 1;
                    end else begin
                        fault_overflow = 1'b1;
                    end
                end
            end
        end
    end

endmodule : ru_fault_allocator

// File: rtl/recompute_module_controller.sv
// -----------------------------------------------------------------------------
// recompute_module_controller
//   Fault-to-recompute-unit allocator for the BISR recompute-unit scheme.
//   Every rising clk edge the allocation is recomputed from the current STW
//   pass/fail matrix and registered (1-cycle latency, no handshake, nothing
//   retained from earlier cycles). Data and weight taps of RU k both mirror
//   the PE assigned to it, so they share the same registered selects.
//
// Ports
//   clk             in   1                       rising-edge clock
//   rst             in   1                       asynchronous, active-low reset
//   STW_result_mat  in   [0:ROWS-1][0:COLS-1]    1 = PE passed, 0 = PE faulty
//   dataRow         out  [ROWS-1:0] x NUM_RU     one-hot row, RU data tap
//   dataCol         out  [COLS-1:0] x NUM_RU     one-hot column, RU data tap
//   weightRow       out  [ROWS-1:0] x NUM_RU     one-hot row, RU weight tap
//   weightCol       out  [COLS-1:0] x NUM_RU     one-hot column, RU weight tap
//   ru_active       out  NUM_RU                  RU k holds a valid assignment
//   fault_overflow  out  1                       more faulty PEs than RUs
// -----------------------------------------------------------------------------
module recompute_module_controller
    import recompute_pkg::*;
#(
    parameter int ROWS   = DEFAULT_ROWS,
    parameter int COLS   = DEFAULT_COLS,
    parameter int NUM_RU = DEFAULT_NUM_RU
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              STW_result_mat [0:ROWS-1][0:COLS-1],
    output logic [ROWS-1:0]   dataRow        [NUM_RU-1:0],
    output logic [COLS-1:0]   dataCol        [NUM_RU-1:0],
    output logic [ROWS-1:0]   weightRow      [NUM_RU-1:0],
    output logic [COLS-1:0]   weightCol      [NUM_RU-1:0],
    output logic [NUM_RU-1:0] ru_active,
    output logic              fault_overflow
);

    logic [ROWS-1:0]   sel_row_d [NUM_RU-1:0];
    logic [COLS-1:0]   sel_col_d [NUM_RU-1:0];
    logic [NUM_RU-1:0] ru_active_d;
    logic              fault_overflow_d;

    logic [ROWS-1:0]   sel_row_q [NUM_RU-1:0];
    logic [COLS-1:0]   sel_col_q [NUM_RU-1:0];
    logic [NUM_RU-1:0] ru_active_q;
    logic              fault_overflow_q;

    ru_fault_allocator #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .NUM_RU (NUM_RU)
    ) u_allocator (
        .stw_result_mat (STW_result_mat),
        .ru_row         (sel_row_d),
        .ru_col         (sel_col_d),
        .ru_active      (ru_active_d),
        .fault_overflow (fault_overflow_d)
    );

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_RU; k++) begin
                sel_row_q[k] <= '0;
                sel_col_q[k] <= '0;
            end
            ru_active_q      <= '0;
            fault_overflow_q <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_RU; k++) begin
                sel_row_q[k] <= sel_row_d[k];
                sel_col_q[k] <= sel_col_d[k];
            end
            ru_active_q      <= ru_active_d;
            fault_overflow_q <= fault_overflow_d;
        end
    end

    assign dataRow        = sel_row_q;
    assign dataCol        = sel_col_q;
    assign weightRow      = sel_row_q;
    assign weightCol      = sel_col_q;
    assign ru_active      = ru_active_q;
    assign fault_overflow = fault_overflow_q;

endmodule : recompute_module_controller

// File: tb/tb_recompute_module_controller.sv
// -----------------------------------------------------------------------------
// tb_recompute_module_controller
//   Scoreboard bench for recompute_module_controller (3x3 array, 3 RUs).
//   Fault patterns are given as a 9-bit mask, bit r*3+c set = PE (r,c) faulty.
// -----------------------------------------------------------------------------
module tb_recompute_module_controller;

    localparam int ROWS   = 3;
    localparam int COLS   = 3;
    localparam int NUM_RU = 3;

    typedef struct packed {
        logic [NUM_RU-1:0][ROWS-1:0] drow;
        logic [NUM_RU-1:0][COLS-1:0] dcol;
        logic [NUM_RU-1:0][ROWS-1:0] wrow;
        logic [NUM_RU-1:0][COLS-1:0] wcol;
        logic [NUM_RU-1:0]           act;
        logic                        ovf;
    } exp_t;

    logic            clk;
    logic            rst;
    logic            mat       [0:ROWS-1][0:COLS-1];
    logic [ROWS-1:0] data_row  [NUM_RU-1:0];
    logic [COLS-1:0] data_col  [NUM_RU-1:0];
    logic [ROWS-1:0] wght_row  [NUM_RU-1:0];
    logic [COLS-1:0] wght_col  [NUM_RU-1:0];
    logic [NUM_RU-1:0] ru_active;
    logic            fault_overflow;

    exp_t sb[$];
    int   vectors;
    int   miscompares;

    recompute_module_controller #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .NUM_RU (NUM_RU)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .STW_result_mat (mat),
        .dataRow        (data_row),
        .dataCol        (data_col),
        .weightRow      (wght_row),
        .weightCol      (wght_col),
        .ru_active      (ru_active),
        .fault_overflow (fault_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1);
    end

    // Hand-written expectation; weight taps always mirror data taps.
    function automatic exp_t mk(input logic [2:0] r0, input logic [2:0] c0,
                                input logic [2:0] r1, input logic [2:0] c1,
                                input logic [2:0] r2, input logic [2:0] c2,
                                input logic [2:0] act, input logic ovf);
        exp_t e;
        e.drow = {r2, r1, r0};
        e.dcol = {c2, c1, c0};
        e.wrow = {r2, r1, r0};
        e.wcol = {c2, c1, c0};
        e.act  = act;
        e.ovf  = ovf;
        return e;
    endfunction

    // Reference model: list all faults, then hand out the first NUM_RU.
    function automatic exp_t model(input logic [8:0] fault_mask);
        exp_t e;
        int   fr[$];
        int   fc[$];
        e = '0;
        for (int i = 0; i < ROWS * COLS; i++) begin
            if (fault_mask[i]) begin
                fr.push_back(i / COLS);
                fc.push_back(i % COLS);
            end
        end
        for (int k = 0; k < NUM_RU; k++) begin
            if (k < fr.size()) begin
                e.drow[k] = 3'(1 << fr[k]);
                e.dcol[k] = 3'(1 << fc[k]);
                e.wrow[k] = 3'(1 << fr[k]);
                e.wcol[k] = 3'(1 << fc[k]);
                e.act[k]  = 1'b1;
            end
        end
        e.ovf = (fr.size() > NUM_RU);
        return e;
    endfunction

    function automatic exp_t observe();
        exp_t o;
        for (int k = 0; k < NUM_RU; k++) begin
            o.drow[k] = data_row[k];
            o.dcol[k] = data_col[k];
            o.wrow[k] = wght_row[k];
            o.wcol[k] = wght_col[k];
        end
        o.act = ru_active;
        o.ovf = fault_overflow;
        return o;
    endfunction

    // Apply a fault mask on the falling edge (away from the sampling edge).
    task automatic drive(input logic [8:0] fault_mask);
        @(negedge clk);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                mat[r][c] = ~fault_mask[r * COLS + c];
    endtask

    task automatic test_reset();
        exp_t got, exp;
        rst = 1'b0;
        drive(9'b100010001);
        sb.push_back('0);
        @(posedge clk); #1;
        got = observe(); exp = sb.pop_front(); vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL reset_hold: got %h required %h", got, exp);
        end
        drive(9'b111111111);
        rst = 1'b1;
    endtask

    task automatic test_diagonal();
        exp_t got, exp;
        drive(9'b100010001);
        sb.push_back(mk(3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b111, 1'b0));
        @(posedge clk); #1;
        got = observe(); exp = sb.pop_front(); vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL diagonal: got %h required %h", got, exp);
        end
    endtask

    task automatic test_single_fault();
        exp_t got, exp;
        drive(9'b000100000);
        sb.push_back(mk(3'b010, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 1'b0));
        @(posedge clk); #1;
        got = observe(); exp = sb.pop_front(); vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL single_1_2: got %h required %h", got, exp);
        end
    endtask

    task automatic test_overflow();
        exp_t got, exp;
        drive(9'b101000110);
        sb.push_back(mk(3'b001, 3'b010, 3'b001, 3'b100, 3'b100, 3'b001, 3'b111, 1'b1));
        @(posedge clk); #1;
        got = observe(); exp = sb.pop_front(); vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL overflow_four: got %h required %h", got, exp);
        end
        drive(9'b111111111);
        sb.push_back(mk(3'b001, 3'b001, 3'b001, 3'b010, 3'b001, 3'b100, 3'b111, 1'b1));
        @(posedge clk); #1;
        got = observe(); exp = sb.pop_front(); vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL overflow_all: got %h required %h", got, exp);
        end
    endtask

    task automatic test_all_pass_then_flip();
        exp_t got, exp;
        drive(9'b000000000);
        sb.push_back('0);
        @(posedge clk); #1;
        got = observe(); exp = sb.pop_front(); vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL all_pass: got %h required %h", got, exp);
        end
        drive(9'b010000000);
        // Before the next edge the registered outputs must still be idle.
        sb.push_back('0);
        #1;
        got = observe(); exp = sb.pop_front(); vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL flip_latency: got %h required %h", got, exp);
        end
        sb.push_back(mk(3'b100, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 1'b0));
        @(posedge clk); #1;
        got = observe(); exp = sb.pop_front(); vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL flip_2_1: got %h required %h", got, exp);
        end
    endtask

    task automatic test_async_reset();
        exp_t got, exp;
        drive(9'b100010001);
        sb.push_back(mk(3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b111, 1'b0));
        @(posedge clk); #1;
        got = observe(); exp = sb.pop_front(); vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL async_pre: got %h required %h", got, exp);
        end
        #2 rst = 1'b0;
        sb.push_back('0);
        #1;
        got = observe(); exp = sb.pop_front(); vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL async_clear: got %h required %h", got, exp);
        end
        sb.push_back('0);
        @(posedge clk); #1;
        got = observe(); exp = sb.pop_front(); vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL async_hold: got %h required %h", got, exp);
        end
        @(negedge clk);
        rst = 1'b1;
        sb.push_back(mk(3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b111, 1'b0));
        @(posedge clk); #1;
        got = observe(); exp = sb.pop_front(); vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL async_release: got %h required %h", got, exp);
        end
    endtask

    task automatic test_back_to_back();
        exp_t        got, exp;
        logic [8:0]  m;
        for (int i = 0; i < 32; i++) begin
            m = 9'($urandom_range(0, 511));
            drive(m);
            sb.push_back(model(m));
            @(posedge clk); #1;
            got = observe(); exp = sb.pop_front(); vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL b2b_%0d mask=%b: got %h required %h", i, m, got, exp);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                mat[r][c] = 1'b1;

        test_reset();
        test_diagonal();
        test_single_fault();
        test_overflow();
        test_all_pass_then_flip();
        test_async_reset();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_recompute_module_controller

// File: doc/recompute_module_controller.md
Name: recompute_module_controller

Overview:
- Fault-to-recompute-unit allocator for the BISR recompute-unit approach.
- Consumes the per-PE pass/fail matrix from the systolic test (STW) stage.
- Assigns each faulty PE, in row-major priority order, to one of NUM_RU spare recompute units (RUs).
- Drives one-hot row/column select vectors so the data and weight taps of the allocated RU mirror the faulty PE.

Parameters:
- ROWS, 3, systolic array rows.
- COLS, 3, systolic array columns.
- NUM_RU, 3, number of spare recompute units.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- STW_result_mat  in  1-bit unpacked [0:ROWS-1][0:COLS-1]  per-PE result; 1 = PE passed, 0 = PE faulty.
- dataRow  out  [ROWS-1:0] x NUM_RU (unpacked [NUM_RU-1:0])  one-hot row of the PE whose data path RU k taps.
- dataCol  out  [COLS-1:0] x NUM_RU  one-hot column of the PE whose data path RU k taps.
- weightRow  out  [ROWS-1:0] x NUM_RU  one-hot row for RU k weight tap.
- weightCol  out  [COLS-1:0] x NUM_RU  one-hot column for RU k weight tap.
- ru_active  out  NUM_RU  RU k holds a valid assignment.
- fault_overflow  out  1  more faulty PEs than NUM_RU.

Behaviour:
- Reset (rst low, asynchronous): all outputs cleared to 0 immediately and held while rst is low.
- Scan order:
  - Each cycle, combinationally scan STW_result_mat in row-major order (r=0..ROWS-1, c=0..COLS-1).
  - Collect the first NUM_RU entries equal to 0.
- Assignment: the n-th fault found (n = 0..NUM_RU-1) goes to RU n.
  - dataRow[n] = weightRow[n] = 1<<r.
  - dataCol[n] = weightCol[n] = 1<<c.
  - ru_active[n] = 1.
- Bit encoding: bit i of a row vector = row i; bit j of a column vector = column j.
- Unused RUs: all four vectors = 0, ru_active = 0.
- Latency: outputs are registered, updated on every rising clk edge from the current matrix. Latency is 1 cycle; no handshake.
- Matrix changes: any change takes effect at the next edge. Previous assignments are not retained; allocation is recomputed fully each cycle.
- Fault count > NUM_RU: the first NUM_RU faults are assigned. fault_overflow = 1 (registered, same edge); remaining faults are ignored.
- Fault count == NUM_RU: all RUs active, fault_overflow = 0.
- No faults: all outputs 0.
- Reset deasserted mid-operation: the first rising edge after release loads a valid allocation.
- Invariants:
  - Each active RU has exactly one bit set in each of its four vectors.
  - No two active RUs share the same (row, col).

Decomposition:
- Shared package recompute_pkg:
  - default ROWS/COLS/NUM_RU constants;
  - localparam for the pass/fail encoding (PE_PASS=1, PE_FAIL=0).
- One natural sub-module: ru_fault_allocator.
  - Purely combinational row-major priority scan producing per-RU row/col one-hots, active flags and overflow.
  - The controller top only registers these outputs with asynchronous active-low reset.

Test Plan:
- Reset: rst=0 with arbitrary matrix -> all dataRow/dataCol/weightRow/weightCol = 0, ru_active=0, fault_overflow=0.
- Diagonal faults (matrix 0 at (0,0),(1,1),(2,2), else 1), rst high -> after next edge:
  - RU0: row 3'b001, col 3'b001.
  - RU1: row 3'b010, col 3'b010.
  - RU2: row 3'b100, col 3'b100.
  - weight vectors equal data vectors; ru_active=3'b111; overflow=0.
- Single fault at (1,2) -> RU0 row 3'b010, col 3'b100; RU1/RU2 all zeros; ru_active=3'b001.
- Four faults at (0,1),(0,2),(2,0),(2,2) -> RU0 (row 001, col 010), RU1 (row 001, col 100), RU2 (row 100, col 001); ru_active=111; fault_overflow=1.
- All-pass matrix -> all vectors 0, ru_active=0, overflow=0. Then flip (2,1) to 0 -> exactly one edge later RU0 row 3'b100, col 3'b010.
- Assert rst low asynchronously between edges while allocations are active -> outputs clear without waiting for clk. Release -> allocations restored on the first edge.
